// File: rtl/pong_pkg.sv
// Shared constants for the animated Pong graphics path: default geometry,
// colours, FSM encoding and a small span-test helper.
package pong_pkg;

    localparam int DEF_MAX_X       = 640;
    localparam int DEF_MAX_Y       = 480;
    localparam int DEF_WALL_X_L    = 32;
    localparam int DEF_WALL_X_R    = 35;
    localparam int DEF_BAR_X_L     = 600;
    localparam int DEF_BAR_X_R     = 603;
    localparam int DEF_BAR_Y_SIZE  = 72;
    localparam int DEF_BAR_V       = 4;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_BALL_V      = 2;
    localparam int DEF_HOLD_FRAMES = 60;
    localparam int DEF_RGB_W       = 4;

    localparam logic [3:0] DEF_WALL_RGB  = 4'ha;
    localparam logic [3:0] DEF_BAR_RGB   = 4'h3;
    localparam logic [3:0] DEF_BALL_RGB  = 4'h9;
    localparam logic [3:0] DEF_BG_RGB    = 4'he;
    localparam logic [3:0] DEF_BLANK_RGB = 4'hf;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_MISS  = 2'd1,
        ST_SERVE = 2'd2
    } pong_state_e;

    // Inclusive range test on 10-bit screen coordinates.
    function automatic logic in_span(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_anim_graph_if.sv
// Pixel-side bundle between the sync counter / button inputs and the
// graphics generator outputs.
interface pong_anim_graph_if #(
    parameter int RGB_W = 4
);
    logic             video_on;
    logic [9:0]       pix_x;
    logic [9:0]       pix_y;
    logic [1:0]       btn;
    logic [RGB_W-1:0] graph_rgb;
    logic             hit;
    logic             miss;

    modport master (
        output video_on, pix_x, pix_y, btn,
        input  graph_rgb, hit, miss
    );

    modport slave (
        input  video_on, pix_x, pix_y, btn,
        output graph_rgb, hit, miss
    );
endinterface

// File: rtl/pong_frame_tick.sv
// One-cycle frame pulse on the first cycle the scan reaches (0, MAX_Y);
// holding that position for several cycles still yields a single pulse.
module pong_frame_tick #(
    parameter int MAX_Y = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       tick
);
    logic match;
    logic match_q;

    assign match = (pix_x == 10'd0) && (pix_y == 10'(MAX_Y));

    always_ff @(posedge clk) begin
        if (reset) match_q <= 1'b0;
        else       match_q <= match;
    end

    assign tick = match & ~match_q;

endmodule

// File: rtl/pong_anim_graph.sv
// Animated Pong object generator: button-driven paddle, bouncing ball with
// miss hold-off and re-serve, and a registered per-pixel colour mux.
module pong_anim_graph
    import pong_pkg::*;
#(
    parameter int MAX_X       = DEF_MAX_X,
    parameter int MAX_Y       = DEF_MAX_Y,
    parameter int WALL_X_L    = DEF_WALL_X_L,
    parameter int WALL_X_R    = DEF_WALL_X_R,
    parameter int BAR_X_L     = DEF_BAR_X_L,
    parameter int BAR_X_R     = DEF_BAR_X_R,
    parameter int BAR_Y_SIZE  = DEF_BAR_Y_SIZE,
    parameter int BAR_V       = DEF_BAR_V,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int BALL_V      = DEF_BALL_V,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int RGB_W       = DEF_RGB_W,
    parameter logic [RGB_W-1:0] WALL_RGB  = RGB_W'(DEF_WALL_RGB),
    parameter logic [RGB_W-1:0] BAR_RGB   = RGB_W'(DEF_BAR_RGB),
    parameter logic [RGB_W-1:0] BALL_RGB  = RGB_W'(DEF_BALL_RGB),
    parameter logic [RGB_W-1:0] BG_RGB    = RGB_W'(DEF_BG_RGB),
    parameter logic [RGB_W-1:0] BLANK_RGB = RGB_W'(DEF_BLANK_RGB)
) (
    input logic              clk,
    input logic              reset,
    pong_anim_graph_if.slave bus
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [9:0]    BAR_INIT      = 10'(MAX_Y / 2 - BAR_Y_SIZE / 2);
    localparam logic [9:0]    BALL_X0       = 10'(MAX_X / 2);
    localparam logic [9:0]    BALL_Y0       = 10'(MAX_Y / 2);
    localparam logic [9:0]    BAR_H1        = 10'(BAR_Y_SIZE - 1);
    localparam logic [9:0]    BALL_S1       = 10'(BALL_SIZE - 1);
    localparam logic [9:0]    BAR_STEP      = 10'(BAR_V);
    localparam logic [9:0]    BALL_STEP     = 10'(BALL_V);
    localparam logic [9:0]    BAR_DN_LIM    = 10'(MAX_Y - 1 - BAR_V);
    localparam logic [9:0]    BALL_BOT_LIM  = 10'(MAX_Y - 1 - BALL_V);
    localparam logic [9:0]    BALL_WALL_LIM = 10'(WALL_X_R + BALL_V);
    localparam logic [9:0]    BALL_MISS_LIM = 10'(BAR_X_R + BALL_V);
    localparam logic [9:0]    WALL_L        = 10'(WALL_X_L);
    localparam logic [9:0]    WALL_R        = 10'(WALL_X_R);
    localparam logic [9:0]    BAR_L         = 10'(BAR_X_L);
    localparam logic [9:0]    BAR_R         = 10'(BAR_X_R);
    localparam logic [HW-1:0] HOLD_LAST     = HW'(HOLD_FRAMES - 1);

    pong_state_e      state_q, state_d;
    logic [HW-1:0]    hold_q;
    logic [9:0]       bar_y_t, bar_y_b;
    logic [9:0]       ball_x, ball_y, ball_r, ball_b;
    logic             ball_dx, ball_dy;
    logic             tick;
    logic             dx_n, dy_n, hit_c, miss_c;
    logic [9:0]       x_n, y_n;
    logic             ball_en, ball_step, ball_load, hold_inc;
    logic             wall_on, bar_on, ball_on;
    logic [RGB_W-1:0] rgb_d, rgb_q;

    pong_frame_tick #(.MAX_Y(MAX_Y)) u_tick (
        .clk   (clk),
        .reset (reset),
        .pix_x (bus.pix_x),
        .pix_y (bus.pix_y),
        .tick  (tick)
    );

    assign bar_y_b = bar_y_t + BAR_H1;
    assign ball_r  = ball_x + BALL_S1;
    assign ball_b  = ball_y + BALL_S1;

    // Reflect from the current position first, then step along the new
    // direction, so the ball can never leave the screen.
    always_comb begin
        dx_n   = ball_dx;
        dy_n   = ball_dy;
        hit_c  = 1'b0;
        miss_c = 1'b0;
        if (ball_y <= BALL_STEP)         dy_n = 1'b1;
        else if (ball_b >= BALL_BOT_LIM) dy_n = 1'b0;
        if (ball_x <= BALL_WALL_LIM)     dx_n = 1'b1;
        if (in_span(ball_r, BAR_L, BAR_R) && (ball_y <= bar_y_b) &&
            (ball_b >= bar_y_t) && ball_dx) begin
            dx_n  = 1'b0;
            hit_c = 1'b1;
        end else if (ball_r > BALL_MISS_LIM) begin
            miss_c = 1'b1;
        end
        x_n = dx_n ? ball_x + BALL_STEP : ball_x - BALL_STEP;
        y_n = dy_n ? ball_y + BALL_STEP : ball_y - BALL_STEP;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_PLAY;
        else       state_q <= state_d;
    end

    // MISS lasts exactly HOLD_FRAMES ticks: the last one moves to SERVE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PLAY:  if (tick && miss_c)              state_d = ST_MISS;
            ST_MISS:  if (tick && hold_q == HOLD_LAST) state_d = ST_SERVE;
            ST_SERVE: state_d = ST_PLAY;
            default:  state_d = ST_PLAY;
        endcase
    end

    always_comb begin
        ball_en   = 1'b0;
        ball_step = 1'b0;
        ball_load = 1'b0;
        hold_inc  = 1'b0;
        unique case (state_q)
            ST_PLAY: begin
                ball_en   = 1'b1;
                ball_step = tick;
            end
            ST_MISS:  hold_inc  = tick && (hold_q != HOLD_LAST);
            ST_SERVE: ball_load = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bar_y_t <= BAR_INIT;
            ball_x  <= BALL_X0;
            ball_y  <= BALL_Y0;
            ball_dx <= 1'b1;
            ball_dy <= 1'b1;
            hold_q  <= '0;
        end else begin
            if (tick) begin
                if (bus.btn == 2'b01 && bar_y_b < BAR_DN_LIM)
                    bar_y_t <= bar_y_t + BAR_STEP;
                else if (bus.btn == 2'b10 && bar_y_t > BAR_STEP)
                    bar_y_t <= bar_y_t - BAR_STEP;
            end
            if (ball_load) begin
                ball_x  <= BALL_X0;
                ball_y  <= BALL_Y0;
                ball_dx <= 1'b1;
                ball_dy <= 1'b1;
            end else if (ball_step) begin
                ball_x  <= x_n;
                ball_y  <= y_n;
                ball_dx <= dx_n;
                ball_dy <= dy_n;
            end
            if (ball_load)     hold_q <= '0;
            else if (hold_inc) hold_q <= hold_q + HW'(1);
        end
    end

    assign bus.hit  = ball_step & hit_c & ~reset;
    assign bus.miss = ball_step & miss_c & ~reset;

    assign wall_on = in_span(bus.pix_x, WALL_L, WALL_R);
    assign bar_on  = in_span(bus.pix_x, BAR_L, BAR_R) && in_span(bus.pix_y, bar_y_t, bar_y_b);
    assign ball_on = ball_en && in_span(bus.pix_x, ball_x, ball_r) &&
                     in_span(bus.pix_y, ball_y, ball_b);

    always_comb begin
        rgb_d = BG_RGB;
        if (!bus.video_on) rgb_d = BLANK_RGB;
        else if (wall_on)  rgb_d = WALL_RGB;
        else if (bar_on)   rgb_d = BAR_RGB;
        else if (ball_on)  rgb_d = BALL_RGB;
    end

    always_ff @(posedge clk) begin
        if (reset) rgb_q <= BLANK_RGB;
        else       rgb_q <= rgb_d;
    end

    assign bus.graph_rgb = rgb_q;

endmodule

// File: tb/tb_pong_anim_graph.sv
// Bench for pong_anim_graph: frame-level game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pong_anim_graph;
    import pong_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pong_anim_graph_if #(.RGB_W(4)) bus ();

    pong_anim_graph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    int   dut_miss_cnt = 0;

    // Model state: positions in plain ints, directions as +1/-1.
    int   m_bar, m_bx, m_by, m_dx, m_dy, m_hidden;
    bit   m_play, m_serve, m_prev_match, m_hit_seen;
    logic [3:0] exp_rgb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_init();
        m_bar = 204; m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
        m_hidden = 0; m_play = 1'b1; m_serve = 1'b0; m_prev_match = 1'b0;
        m_hit_seen = 1'b0;
    endfunction

    function automatic logic [3:0] colour(input int x, input int y, input bit v);
        if (!v) return 4'hf;
        if (x >= 32 && x <= 35) return 4'ha;
        if (x >= 600 && x <= 603 && y >= m_bar && y < m_bar + 72) return 4'h3;
        if (m_play && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 4'h9;
        return 4'he;
    endfunction

    always @(negedge clk) begin : cmp
        bit mt, tk, eh, em;
        int ndx, ndy;
        if (chk_en) begin
            chk("graph_rgb", 32'(bus.graph_rgb), 32'(exp_rgb));
            chk("bar_y_t", 32'(dut.bar_y_t), m_bar);
            chk("ball_x", 32'(dut.ball_x), m_bx);
            chk("ball_y", 32'(dut.ball_y), m_by);
            chk("ball_dx", 32'(dut.ball_dx), 32'(m_dx > 0));
            mt  = (bus.pix_x == 10'd0) && (bus.pix_y == 10'd480);
            tk  = mt && !m_prev_match && !reset;
            eh  = 1'b0; em = 1'b0; ndx = m_dx; ndy = m_dy;
            if (tk && m_play) begin
                if (m_by <= 2) ndy = 1;
                else if (m_by + 7 >= 477) ndy = -1;
                if (m_bx <= 37) ndx = 1;
                eh = (m_bx + 7 >= 600) && (m_bx + 7 <= 603) && (m_by <= m_bar + 71) &&
                     (m_by + 7 >= m_bar) && (m_dx == 1);
                if (eh) ndx = -1;
                em = !eh && (m_bx + 7 > 605);
            end
            chk("hit", 32'(bus.hit), 32'(eh));
            chk("miss", 32'(bus.miss), 32'(em));
            if (bus.miss === 1'b1) dut_miss_cnt++;
            exp_rgb = reset ? 4'hf : colour(int'(bus.pix_x), int'(bus.pix_y), bus.video_on);
            if (reset) model_init();
            else if (m_serve) begin
                m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
                m_play = 1'b1; m_serve = 1'b0;
            end else if (tk) begin
                if (bus.btn == 2'b01 && m_bar + 71 < 475) m_bar += 4;
                else if (bus.btn == 2'b10 && m_bar > 4) m_bar -= 4;
                if (m_play) begin
                    m_bx += 2 * ndx; m_by += 2 * ndy; m_dx = ndx; m_dy = ndy;
                    if (eh) m_hit_seen = 1'b1;
                    if (em) begin m_play = 1'b0; m_hidden = 0; end
                end else begin
                    m_hidden++;
                    if (m_hidden == 60) m_serve = 1'b1;
                end
            end
            m_prev_match = reset ? 1'b0 : mt;
        end
    end

    task automatic cyc(input int x, input int y, input bit v);
        bus.pix_x = 10'(x); bus.pix_y = 10'(y); bus.video_on = v;
        @(posedge clk); #1;
    endtask

    task automatic probe(input int x, input int y, input bit v, input logic [3:0] e, input string nm);
        cyc(x, y, v);
        chk(nm, 32'(bus.graph_rgb), 32'(e));
    endtask

    // One frame: the tick position, then pixels over the ball, the paddle
    // and a random spot so the colour mux is exercised every frame.
    task automatic frame();
        cyc(0, 480, 1'b0);
        cyc(m_bx + 3, m_by + 3, 1'b1);
        cyc(601, m_bar, 1'b1);
        cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(5, 5, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        int n, h, pre;
        model_init();
        exp_rgb = 4'hf;
        bus.video_on = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.btn = 2'b00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        reset  = 1'b0;

        chk("rst_bar", 32'(dut.bar_y_t), 204);
        chk("rst_ball_x", 32'(dut.ball_x), 320);
        chk("rst_rgb", 32'(bus.graph_rgb), 32'h f);
        chk("rst_hit", 32'(bus.hit), 0);

        probe(0, 0, 1'b1, 4'he, "draw_bg");
        probe(33, 0, 1'b1, 4'ha, "draw_wall");
        probe(33, 0, 1'b0, 4'hf, "draw_blank");
        probe(601, 210, 1'b1, 4'h3, "draw_bar");
        probe(323, 243, 1'b1, 4'h9, "draw_ball");

        // Free run: bottom bounce, miss, hold-off, re-serve.
        bus.btn = 2'b00;
        for (int i = 0; i < 116; i++) frame();
        chk("bounce_y", 32'(dut.ball_y), 468);
        chk("bounce_dy", 32'(dut.ball_dy), 0);
        chk("bounce_x", 32'(dut.ball_x), 552);
        n = 116;
        while (m_play && n < 300) begin frame(); n++; end
        chk("frames_to_miss", n, 141);
        chk("miss_state", 32'(dut.state_q), 32'(ST_MISS));
        h = 0;
        while (!m_play && h < 200) begin frame(); h++; end
        chk("hold_frames", h, 60);
        chk("miss_pulses", dut_miss_cnt, 1);
        probe(323, 243, 1'b1, 4'h9, "served_ball");
        chk("served_x", 32'(dut.ball_x), 320);
        chk("served_y", 32'(dut.ball_y), 240);

        // Paddle motion, multi-cycle match, limits, then a paddle return.
        do_reset();
        bus.btn = 2'b01;
        for (int i = 0; i < 10; i++) frame();
        chk("bar_10", 32'(dut.bar_y_t), 244);
        for (int i = 0; i < 5; i++) cyc(0, 480, 1'b0);
        cyc(5, 5, 1'b1);
        chk("bar_held_match", 32'(dut.bar_y_t), 248);
        for (int i = 0; i < 100; i++) frame();
        chk("bar_limit", 32'(dut.bar_y_t), 404);
        bus.btn = 2'b11;
        for (int i = 0; i < 5; i++) frame();
        chk("bar_btn11", 32'(dut.bar_y_t), 404);
        bus.btn = 2'b01;
        n = 116;
        while (!m_hit_seen && n < 300) begin frame(); n++; end
        chk("frames_to_hit", n, 138);
        chk("hit_dx", 32'(dut.ball_dx), 0);
        chk("hit_x", 32'(dut.ball_x), 592);
        pre = -1;
        for (int i = 0; i < 400; i++) begin
            pre = m_bx;
            frame();
            if (m_dx == 1) break;
        end
        chk("wall_reflect_x", pre, 36);
        chk("wall_dx", 32'(dut.ball_dx), 1);

        // Reset in the middle of the hold-off.
        do_reset();
        bus.btn = 2'b00;
        n = 0;
        while (m_play && n < 300) begin frame(); n++; end
        for (int i = 0; i < 10; i++) frame();
        chk("pre_reset_state", 32'(dut.state_q), 32'(ST_MISS));
        reset = 1'b1;
        cyc(100, 100, 1'b1);
        chk("mid_rst_state", 32'(dut.state_q), 32'(ST_PLAY));
        chk("mid_rst_x", 32'(dut.ball_x), 320);
        chk("mid_rst_y", 32'(dut.ball_y), 240);
        chk("mid_rst_bar", 32'(dut.bar_y_t), 204);
        chk("mid_rst_rgb", 32'(bus.graph_rgb), 32'h f);
        reset = 1'b0;
        cyc(5, 5, 1'b1);
        cyc(5, 5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
